// File: rtl/nn_job_scheduler.sv
// Round-robin scheduler that shares one neural-network datapath/controller between two requesters.
// Grants one job at a time, counts controller iterations, aborts at the limit and returns a tagged result.
module nn_job_scheduler #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic              grant_sel,
  output logic              nn_start,
  input  logic              nn_iter,
  input  logic              nn_done,
  output logic              nn_abort,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_timeout,
  output logic [ITER_W-1:0] rsp_iters
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [ITER_W-1:0] LP_ONE   = ITER_W'(1);
  localparam logic [ITER_W-1:0] LP_SAT   = '1;
  localparam logic [ITER_W-1:0] LP_LIMIT = ITER_W'(MAX_ITER - 1);
  localparam logic [ITER_W-1:0] LP_MAX   = ITER_W'(MAX_ITER);

  state_t            r_state;
  logic              r_rr_ptr;
  logic              r_grant_sel;
  logic              r_req0_ready;
  logic              r_req1_ready;
  logic              r_nn_start;
  logic              r_nn_abort;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic              r_rsp_timeout;
  logic [ITER_W-1:0] r_iter_cnt;
  logic [ITER_W-1:0] r_rsp_iters;

  logic              w_any_valid;
  logic              w_winner;
  logic              w_timeout;
  logic [ITER_W-1:0] w_iter_next;

  // Round-robin pointer only matters when both requesters compete.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_winner    = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
  assign w_iter_next = (nn_iter && (r_iter_cnt != LP_SAT)) ? (r_iter_cnt + LP_ONE) : r_iter_cnt;
  assign w_timeout   = nn_iter & (r_iter_cnt == LP_LIMIT) & ~nn_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= 1'b0;
      r_grant_sel   <= 1'b0;
      r_req0_ready  <= 1'b0;
      r_req1_ready  <= 1'b0;
      r_nn_start    <= 1'b0;
      r_nn_abort    <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_iter_cnt    <= '0;
      r_rsp_iters   <= '0;
    end else begin
      r_req0_ready <= 1'b0;
      r_req1_ready <= 1'b0;
      r_nn_start   <= 1'b0;
      r_nn_abort   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_grant_sel  <= w_winner;
            r_req0_ready <= ~w_winner;
            r_req1_ready <= w_winner;
            r_nn_start   <= 1'b1;
            r_state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_iter_cnt <= '0;
          r_rr_ptr   <= ~r_grant_sel;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          r_iter_cnt <= w_iter_next;
          // A completion landing on the limiting iteration counts as a normal finish.
          if (nn_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_grant_sel;
            r_rsp_timeout <= 1'b0;
            r_rsp_iters   <= w_iter_next;
            r_state       <= S_RESP;
          end else if (w_timeout) begin
            r_nn_abort    <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_grant_sel;
            r_rsp_timeout <= 1'b1;
            r_rsp_iters   <= LP_MAX;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_ready  = r_req0_ready;
  assign req1_ready  = r_req1_ready;
  assign grant_sel   = r_grant_sel;
  assign nn_start    = r_nn_start;
  assign nn_abort    = r_nn_abort;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_iters   = r_rsp_iters;

endmodule

// File: tb/tb_nn_job_scheduler.sv
// Self-checking bench: two scheduler instances (MAX_ITER 64 and 4) share stimulus and are
// compared every cycle against a job-level reference model, plus directed literal checks.
module tb_nn_job_scheduler;

  localparam int ITER_W = 8;
  localparam int MAX_A  = 64;
  localparam int MAX_B  = 4;
  localparam int SAT    = (1 << ITER_W) - 1;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic req0Valid = 1'b0;
  logic req1Valid = 1'b0;
  logic nnIter    = 1'b0;
  logic nnDone    = 1'b0;
  logic rspReady  = 1'b0;

  logic [1:0] req0Ready, req1Ready, grantSel, nnStart, nnAbort, rspValid, rspId, rspTimeout;
  logic [1:0][ITER_W-1:0] rspIters;

  int compared   = 0;
  int mismatched = 0;

  bit expReady0[2], expReady1[2], expGrant[2], expStart[2], expAbort[2];
  bit expRspValid[2], expRspId[2], expTimeout[2], rrModel[2];
  int expIters[2];

  int grantLog[$];
  int rspLog[$];
  int abortCountB = 0;
  int req1CountA  = 0;

  always #5 clk = ~clk;

  nn_job_scheduler #(.ITER_W(ITER_W), .MAX_ITER(MAX_A)) u_dutA (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0Valid), .req0_ready(req0Ready[0]),
    .req1_valid(req1Valid), .req1_ready(req1Ready[0]),
    .grant_sel(grantSel[0]), .nn_start(nnStart[0]),
    .nn_iter(nnIter), .nn_done(nnDone), .nn_abort(nnAbort[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady), .rsp_id(rspId[0]),
    .rsp_timeout(rspTimeout[0]), .rsp_iters(rspIters[0])
  );

  nn_job_scheduler #(.ITER_W(ITER_W), .MAX_ITER(MAX_B)) u_dutB (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0Valid), .req0_ready(req0Ready[1]),
    .req1_valid(req1Valid), .req1_ready(req1Ready[1]),
    .grant_sel(grantSel[1]), .nn_start(nnStart[1]),
    .nn_iter(nnIter), .nn_done(nnDone), .nn_abort(nnAbort[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady), .rsp_id(rspId[1]),
    .rsp_timeout(rspTimeout[1]), .rsp_iters(rspIters[1])
  );

  task automatic checkBit(input string name, input logic act, input bit expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %b, required %0b", name, $time, act, expv);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, required %0d", name, $time, act, expv);
    end
  endtask

  // Reference model: one job at a time, described as a sequence of waits on clock edges.
  task automatic stepModel(output bit wasReset);
    @(posedge clk or negedge rst_n);
    wasReset = !rst_n;
  endtask

  task automatic setIdleExp(input int inst);
    expReady0[inst]   = 1'b0;
    expReady1[inst]   = 1'b0;
    expStart[inst]    = 1'b0;
    expAbort[inst]    = 1'b0;
    expRspValid[inst] = 1'b0;
  endtask

  task automatic resetModel(input int inst);
    setIdleExp(inst);
    expGrant[inst]   = 1'b0;
    expRspId[inst]   = 1'b0;
    expTimeout[inst] = 1'b0;
    expIters[inst]   = 0;
    rrModel[inst]    = 1'b0;
  endtask

  task automatic runJob(input int inst, input int maxIter);
    bit rs;
    bit winner;
    int iters;
    setIdleExp(inst);
    do begin
      stepModel(rs);
      if (rs) return;
    end while (!(req0Valid || req1Valid));
    winner = (req0Valid && req1Valid) ? rrModel[inst] : req1Valid;
    expGrant[inst]  = winner;
    expReady0[inst] = !winner;
    expReady1[inst] = winner;
    expStart[inst]  = 1'b1;
    stepModel(rs);
    if (rs) return;
    expReady0[inst] = 1'b0;
    expReady1[inst] = 1'b0;
    expStart[inst]  = 1'b0;
    rrModel[inst]   = !winner;
    iters = 0;
    forever begin
      stepModel(rs);
      if (rs) return;
      if (nnDone) begin
        expIters[inst]   = (nnIter && iters < SAT) ? iters + 1 : iters;
        expTimeout[inst] = 1'b0;
        break;
      end
      if (nnIter && iters == maxIter - 1) begin
        expIters[inst]   = maxIter;
        expTimeout[inst] = 1'b1;
        expAbort[inst]   = 1'b1;
        break;
      end
      if (nnIter && iters < SAT) iters++;
    end
    expRspValid[inst] = 1'b1;
    expRspId[inst]    = winner;
    do begin
      stepModel(rs);
      if (rs) return;
      expAbort[inst] = 1'b0;
    end while (!rspReady);
  endtask

  task automatic modelProcess(input int inst, input int maxIter);
    forever begin
      if (!rst_n) begin
        resetModel(inst);
        @(posedge rst_n);
      end
      runJob(inst, maxIter);
    end
  endtask

  initial modelProcess(0, MAX_A);
  initial modelProcess(1, MAX_B);

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      checkBit($sformatf("req0_ready[%0d]", i), req0Ready[i], expReady0[i]);
      checkBit($sformatf("req1_ready[%0d]", i), req1Ready[i], expReady1[i]);
      checkBit($sformatf("grant_sel[%0d]", i), grantSel[i], expGrant[i]);
      checkBit($sformatf("nn_start[%0d]", i), nnStart[i], expStart[i]);
      checkBit($sformatf("nn_abort[%0d]", i), nnAbort[i], expAbort[i]);
      checkBit($sformatf("rsp_valid[%0d]", i), rspValid[i], expRspValid[i]);
      if (expRspValid[i] || !rst_n) begin
        checkBit($sformatf("rsp_id[%0d]", i), rspId[i], expRspId[i]);
        checkBit($sformatf("rsp_timeout[%0d]", i), rspTimeout[i], expTimeout[i]);
        compared++;
        if (rspIters[i] !== ITER_W'(expIters[i])) begin
          mismatched++;
          $display("[TB] FAIL rsp_iters[%0d] at %0t: got %0d, required %0d",
                   i, $time, rspIters[i], expIters[i]);
        end
      end
    end
  endtask

  always @(negedge clk) checkOutput();

  // Event log used by the directed literal checks.
  always @(negedge clk) begin
    if (nnStart[0]) grantLog.push_back(int'(grantSel[0]));
    if (rspValid[0] && rspReady) rspLog.push_back(int'(rspId[0]));
    if (nnAbort[1]) abortCountB++;
    if (req1Ready[0]) req1CountA++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitStart(input string name);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (nnStart[0]) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got no nn_start in 20 cycles, required one", name);
  endtask

  // Called in the GRANT cycle; leaves the bench in the first RESP cycle when withDone is set.
  task automatic runNetwork(input int iters, input bit withDone);
    tick();
    nnIter = 1'b1;
    repeat (iters) tick();
    nnIter = 1'b0;
    if (withDone) begin
      nnDone = 1'b1;
      tick();
      nnDone = 1'b0;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      req0Valid = ($urandom_range(0, 3) != 0);
      req1Valid = ($urandom_range(0, 2) != 0);
      nnIter    = ($urandom_range(0, 2) == 0);
      nnDone    = ($urandom_range(0, 11) == 0);
      rspReady  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    nnIter    = 1'b0;
    nnDone    = 1'b0;
    rspReady  = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int grantBase, rspBase, abortBase, req1Base;

    tick();
    tick();
    checkValue("reset_pulses", int'({req0Ready, req1Ready, nnStart, nnAbort, rspValid}), 0);
    checkValue("reset_fields", int'({grantSel, rspId, rspTimeout, rspIters}), 0);
    rst_n = 1'b1;

    // Single job from requester 0: 5 iterations then done.
    rspReady = 1'b1;
    tick();
    req1Base  = req1CountA;
    req0Valid = 1'b1;
    tick();
    checkValue("single_req0_ready", req0Ready[0], 1);
    checkValue("single_nn_start", nnStart[0], 1);
    checkValue("single_grant_sel", grantSel[0], 0);
    req0Valid = 1'b0;
    runNetwork(5, 1'b1);
    checkValue("single_rsp_valid", rspValid[0], 1);
    checkValue("single_rsp_id", rspId[0], 0);
    checkValue("single_rsp_iters", rspIters[0], 5);
    checkValue("single_rsp_timeout", rspTimeout[0], 0);
    tick();
    checkValue("single_no_req1_ready", req1CountA - req1Base, 0);

    // Contention: both valid for four jobs.
    doReset();
    grantBase = grantLog.size();
    rspBase   = rspLog.size();
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      waitStart($sformatf("contention_start%0d", j));
      if (j == 3) begin
        req0Valid = 1'b0;
        req1Valid = 1'b0;
      end
      runNetwork(2, 1'b1);
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      checkValue($sformatf("contention_grant%0d", j),
                 (grantLog.size() > grantBase + j) ? grantLog[grantBase + j] : -1, j % 2);
      checkValue($sformatf("contention_rsp_id%0d", j),
                 (rspLog.size() > rspBase + j) ? rspLog[rspBase + j] : -1, j % 2);
    end

    // Timeout on the MAX_ITER=4 instance.
    abortBase = abortCountB;
    req0Valid = 1'b1;
    waitStart("timeout_start");
    req0Valid = 1'b0;
    runNetwork(4, 1'b0);
    checkValue("timeout_abort_pulse", nnAbort[1], 1);
    checkValue("timeout_rsp_valid", rspValid[1], 1);
    checkValue("timeout_flag", rspTimeout[1], 1);
    checkValue("timeout_iters", rspIters[1], 4);
    tick();
    tick();
    nnDone = 1'b1;
    tick();
    nnDone = 1'b0;
    checkValue("timeout_wide_instance_flag", rspTimeout[0], 0);
    tick();
    checkValue("timeout_abort_count", abortCountB - abortBase, 1);

    // Done on the same cycle as the limiting iteration.
    abortBase = abortCountB;
    req0Valid = 1'b1;
    waitStart("tie_start");
    req0Valid = 1'b0;
    runNetwork(3, 1'b0);
    nnIter = 1'b1;
    nnDone = 1'b1;
    tick();
    nnIter = 1'b0;
    nnDone = 1'b0;
    checkValue("tie_rsp_valid", rspValid[1], 1);
    checkValue("tie_timeout", rspTimeout[1], 0);
    checkValue("tie_iters", rspIters[1], 4);
    checkValue("tie_abort", nnAbort[1], 0);
    tick();
    tick();
    checkValue("tie_abort_count", abortCountB - abortBase, 0);

    // Response backpressure with requester 1 waiting and a stray done.
    rspReady  = 1'b0;
    req0Valid = 1'b1;
    waitStart("bp_start");
    req0Valid = 1'b0;
    runNetwork(2, 1'b1);
    req1Valid = 1'b1;
    req1Base  = req1CountA;
    for (int k = 0; k < 6; k++) begin
      nnDone = (k == 2);
      tick();
      nnDone = 1'b0;
    end
    checkValue("bp_rsp_valid_held", rspValid[0], 1);
    checkValue("bp_rsp_iters_held", rspIters[0], 2);
    checkValue("bp_rsp_id_held", rspId[0], 0);
    checkValue("bp_no_early_req1_ready", req1CountA - req1Base, 0);
    rspReady = 1'b1;
    tick();
    checkValue("bp_rsp_valid_dropped", rspValid[0], 0);
    checkValue("bp_req1_ready_not_yet", req1Ready[0], 0);
    tick();
    checkValue("bp_req1_ready", req1Ready[0], 1);
    checkValue("bp_grant_sel", grantSel[0], 1);
    req1Valid = 1'b0;
    runNetwork(1, 1'b1);
    tick();

    // Asynchronous reset in the middle of a requester-1 job with three iterations counted.
    req1Valid = 1'b1;
    waitStart("rst_start");
    req1Valid = 1'b0;
    tick();
    nnIter = 1'b1;
    repeat (3) tick();
    nnIter = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkValue("rst_grant_sel", int'(grantSel), 0);
    checkValue("rst_pulses", int'({req0Ready, req1Ready, nnStart, nnAbort, rspValid}), 0);
    checkValue("rst_rsp_id", int'(rspId), 0);
    checkValue("rst_rsp_iters_a", rspIters[0], 0);
    checkValue("rst_rsp_iters_b", rspIters[1], 0);
    tick();
    rst_n     = 1'b1;
    req1Valid = 1'b1;
    waitStart("post_rst_start");
    checkValue("post_rst_req1_ready", req1Ready[0], 1);
    checkValue("post_rst_grant_sel", grantSel[0], 1);
    req1Valid = 1'b0;
    runNetwork(2, 1'b1);
    checkValue("post_rst_rsp_id", rspId[0], 1);
    checkValue("post_rst_iters_a", rspIters[0], 2);
    checkValue("post_rst_iters_b", rspIters[1], 2);
    tick();

    applyStimulus(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: still running at %0t, required completion before 2000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/nn_job_scheduler.md
Name: nn_job_scheduler

Overview:
- Shares the single neural-network datapath/controller pair between two requesters.
- Arbitrates pending jobs round-robin and drives the datapath input-mux select.
- Issues a one-cycle start to the network controller and counts iterations until done, aborting on an iteration limit.
- Returns a tagged result handshake to the requester that owned the job.

Parameters:
- ITER_W, 8, width of the iteration counter and rsp_iters.
- MAX_ITER, 64, iteration limit before abort; valid range 1..2^ITER_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a job pending; held high until accepted.
- req0_ready  out  1  acceptance pulse for requester 0.
- req1_valid  in  1  requester 1 has a job pending; held high until accepted.
- req1_ready  out  1  acceptance pulse for requester 1.
- grant_sel  out  1  datapath input-mux select (0=req0 data, 1=req1 data).
- nn_start  out  1  one-cycle start pulse to the network controller.
- nn_iter  in  1  one-cycle pulse per completed network iteration.
- nn_done  in  1  one-cycle pulse when the network controller finishes.
- nn_abort  out  1  one-cycle pulse forcing the network controller back to idle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester that owns the result.
- rsp_timeout  out  1  job ended by the iteration limit, not by nn_done.
- rsp_iters  out  ITER_W  iterations counted for the job.

Behaviour:
- Reset (async, rst_n=0): state IDLE, rr_ptr=0, grant_sel=0, iter_cnt=0. All outputs are 0: ready pulses, nn_start, nn_abort, rsp_valid, rsp_id, rsp_timeout, rsp_iters.
- Reset mid-job clears everything immediately. The network controller is not aborted; integration ties rst_n to it.
- IDLE state:
  - If any reqX_valid is high, go to GRANT.
  - Winner: if both are valid, the winner is rr_ptr. Otherwise the single valid requester wins.
  - Register grant_sel=winner.
- GRANT state (exactly 1 cycle):
  - Assert reqX_ready for the winner only, and nn_start=1.
  - Clear iter_cnt.
  - Set rr_ptr = ~winner.
  - Go to RUN.
  - Latency: valid seen in IDLE cycle N gives ready and start in cycle N+1.
- RUN state:
  - nn_iter increments iter_cnt, saturating at 2^ITER_W-1.
  - nn_done: go to RESP with rsp_timeout=0. rsp_iters = iter_cnt, plus 1 if nn_iter is high the same cycle.
  - Timeout condition: nn_iter while iter_cnt==MAX_ITER-1 and nn_done=0. Pulse nn_abort for 1 cycle (the cycle after the condition) and go to RESP with rsp_timeout=1, rsp_iters=MAX_ITER.
  - nn_done and timeout in the same cycle: nn_done wins, no abort.
- RESP state:
  - rsp_valid=1. rsp_id=grant_sel; rsp_timeout and rsp_iters are held stable.
  - grant_sel is held from GRANT through RESP.
  - Leave RESP on rsp_valid&rsp_ready; rsp_valid drops the next cycle, returning to IDLE.
  - rsp_ready may be tied high: RESP then lasts 1 cycle.
- No new grant while in GRANT, RUN or RESP. Only one job is in flight.
- nn_done and nn_iter pulses outside RUN are ignored.
- reqX_valid deasserting without acceptance is legal; it simply loses arbitration eligibility.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

Test Plan:
- Single job:
  - Stimulus: req0_valid at cycle 2; 5 nn_iter pulses, then nn_done.
  - Required: req0_ready and nn_start at cycle 3; grant_sel=0.
  - Required: rsp_valid with rsp_id=0, rsp_iters=5, rsp_timeout=0; req1_ready never asserted.
- Contention:
  - Stimulus: req0_valid and req1_valid both held high for 4 jobs, rsp_ready=1.
  - Required: grant order 0,1,0,1, each with the matching grant_sel and rsp_id.
- Timeout:
  - Stimulus: MAX_ITER=4; 4 nn_iter pulses and no nn_done.
  - Required: nn_abort pulses once, rsp_timeout=1, rsp_iters=4.
- Done/timeout tie:
  - Stimulus: MAX_ITER=4; 4th nn_iter in the same cycle as nn_done.
  - Required: no nn_abort, rsp_timeout=0, rsp_iters=4.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 6 cycles after done, with req1_valid high.
  - Required: rsp_valid and fields stable; no req1_ready until 1 cycle after the rsp handshake.
  - Required: stray nn_done during RESP is ignored.
- Async reset mid-RUN:
  - Stimulus: rst_n low between clock edges with iter_cnt=3.
  - Required: all outputs 0 immediately; after release, req1_valid alone is granted with rsp_iters counted from 0.
